// File: rtl/kd_pattern_checker.sv
//------------------------------------------------------------------------------
// kd_pattern_checker : receive-side checker for the 268-symbol GTX K/D test
// frame. Optional mismatch capture outputs: define KDCHK_ERR_CAPTURE_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module kd_pattern_checker #(
   parameter int LOCK_THRESH = 16,
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16,
   parameter int FRM_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [7:0]       data_i,
   input  logic             k_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_pulse_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [FRM_W-1:0] frame_cnt_o,
   output logic [1:0]       state_o
`ifdef KDCHK_ERR_CAPTURE_EN
   ,
   output logic             cap_valid_o,
   output logic [8:0]       cap_rx_o,
   output logic [8:0]       cap_exp_o,
   output logic [8:0]       cap_idx_o
`endif
);

   localparam logic [1:0] ST_HUNT  = 2'b00;
   localparam logic [1:0] ST_SYNC  = 2'b01;
   localparam logic [1:0] ST_CHECK = 2'b10;

   localparam logic [8:0] LAST_IDX = 9'd267;
   localparam logic [8:0] K28_0    = {1'b1, 8'h1C};

   localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
   localparam int MISS_W = $clog2(LOSS_THRESH + 1);

   logic [1:0]       state_q,     state_d;
   logic [8:0]       idx_q,       idx_d;
   logic [RUN_W-1:0] run_q,       run_d;
   logic [MISS_W-1:0] miss_q,     miss_d;
   logic             err_seen_q,  err_seen_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;

`ifdef KDCHK_ERR_CAPTURE_EN
   logic             cap_valid_q, cap_valid_d;
   logic [8:0]       cap_rx_q,    cap_rx_d;
   logic [8:0]       cap_exp_q,   cap_exp_d;
   logic [8:0]       cap_idx_q,   cap_idx_d;
`endif

   logic [8:0] rx_sym;
   logic [8:0] exp_sym_w;
   logic [8:0] idx_inc;
   logic       match;

   // Frame layout: 12 K symbols, then the D byte ramp 0x00..0xFF.
   function automatic logic [8:0] exp_sym(input logic [8:0] idx);
      logic [8:0] off;
      off = idx - 9'd12;
      case (idx)
         9'd0:    exp_sym = {1'b1, 8'h1C};
         9'd1:    exp_sym = {1'b1, 8'h3C};
         9'd2:    exp_sym = {1'b1, 8'h5C};
         9'd3:    exp_sym = {1'b1, 8'h7C};
         9'd4:    exp_sym = {1'b1, 8'h9C};
         9'd5:    exp_sym = {1'b1, 8'hBC};
         9'd6:    exp_sym = {1'b1, 8'hDC};
         9'd7:    exp_sym = {1'b1, 8'hFC};
         9'd8:    exp_sym = {1'b1, 8'hF7};
         9'd9:    exp_sym = {1'b1, 8'hFB};
         9'd10:   exp_sym = {1'b1, 8'hFD};
         9'd11:   exp_sym = {1'b1, 8'hFE};
         default: exp_sym = {1'b0, off[7:0]};
      endcase
   endfunction

   assign rx_sym    = {k_i, data_i};
   assign exp_sym_w = exp_sym(idx_q);
   assign match     = (rx_sym == exp_sym_w);
   assign idx_inc   = (idx_q == LAST_IDX) ? 9'd0 : idx_q + 9'd1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      run_d       = run_q;
      miss_d      = miss_q;
      err_seen_d  = err_seen_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      frame_cnt_d = frame_cnt_q;
`ifdef KDCHK_ERR_CAPTURE_EN
      cap_valid_d = cap_valid_q;
      cap_rx_d    = cap_rx_q;
      cap_exp_d   = cap_exp_q;
      cap_idx_d   = cap_idx_q;
`endif

      if (valid_i) begin
         case (state_q)
            ST_HUNT: begin
               if (rx_sym == K28_0) begin
                  state_d    = ST_SYNC;
                  idx_d      = 9'd1;
                  run_d      = RUN_W'(1);
                  miss_d     = '0;
                  err_seen_d = 1'b0;
               end
            end

            ST_SYNC: begin
               if (match) begin
                  idx_d = idx_inc;
                  run_d = run_q + RUN_W'(1);
                  if (run_q + RUN_W'(1) == RUN_W'(LOCK_THRESH)) begin
                     state_d = ST_CHECK;
                     run_d   = '0;
                  end
               end else begin
                  state_d     = ST_HUNT;
                  idx_d       = 9'd0;
                  run_d       = '0;
                  err_pulse_d = 1'b1;
               end
            end

            ST_CHECK: begin
               // Index always advances so a corrupted symbol never slips alignment.
               idx_d = idx_inc;
               if (idx_q == 9'd0) begin
                  err_seen_d = ~match;
               end else if (!match) begin
                  err_seen_d = 1'b1;
               end
               if (idx_q == LAST_IDX && match && !err_seen_q) begin
                  frame_cnt_d = frame_cnt_q + FRM_W'(1);
               end

               if (match) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  miss_d      = miss_q + MISS_W'(1);
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
`ifdef KDCHK_ERR_CAPTURE_EN
                  if (!cap_valid_q) begin
                     cap_valid_d = 1'b1;
                     cap_rx_d    = rx_sym;
                     cap_exp_d   = exp_sym_w;
                     cap_idx_d   = idx_q;
                  end
`endif
                  if (miss_q + MISS_W'(1) == MISS_W'(LOSS_THRESH)) begin
                     state_d = ST_HUNT;
                     idx_d   = 9'd0;
                     miss_d  = '0;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               idx_d   = 9'd0;
               run_d   = '0;
               miss_d  = '0;
            end
         endcase
      end

      // Clear overrides any same-cycle count; the error strobe is untouched.
      if (clear_i) begin
         err_cnt_d   = '0;
         frame_cnt_d = '0;
`ifdef KDCHK_ERR_CAPTURE_EN
         cap_valid_d = 1'b0;
         cap_rx_d    = '0;
         cap_exp_d   = '0;
         cap_idx_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_HUNT;
         idx_q       <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         err_seen_q  <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         err_seen_q  <= err_seen_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

`ifdef KDCHK_ERR_CAPTURE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cap_valid_q <= 1'b0;
         cap_rx_q    <= '0;
         cap_exp_q   <= '0;
         cap_idx_q   <= '0;
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_rx_q    <= cap_rx_d;
         cap_exp_q   <= cap_exp_d;
         cap_idx_q   <= cap_idx_d;
      end
   end

   assign cap_valid_o = cap_valid_q;
   assign cap_rx_o    = cap_rx_q;
   assign cap_exp_o   = cap_exp_q;
   assign cap_idx_o   = cap_idx_q;
`endif

   assign locked_o    = (state_q == ST_CHECK);
   assign err_pulse_o = err_pulse_q;
   assign err_cnt_o   = err_cnt_q;
   assign frame_cnt_o = frame_cnt_q;
   assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_kd_pattern_checker.sv
//------------------------------------------------------------------------------
// tb_kd_pattern_checker : directed bench for kd_pattern_checker (vector table
// for hunt/sync, hand-written sequences for framing, loss, clear and reset).
//------------------------------------------------------------------------------
`default_nettype none

module tb_kd_pattern_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [7:0]  data;
   logic        k;
   logic        clear;

   logic        locked, err_pulse;
   logic [15:0] err_cnt, frame_cnt;
   logic [1:0]  state;

   logic        locked4, err_pulse4;
   logic [3:0]  err_cnt4;
   logic [15:0] frame_cnt4;
   logic [1:0]  state4;

`ifdef KDCHK_ERR_CAPTURE_EN
   logic        cap_valid, cap_valid4;
   logic [8:0]  cap_rx, cap_exp, cap_idx, cap_rx4, cap_exp4, cap_idx4;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int tb_idx  = 0;

   always #5 clk = ~clk;

   kd_pattern_checker #(.LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(16), .FRM_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .k_i(k), .clear_i(clear),
      .locked_o(locked), .err_pulse_o(err_pulse), .err_cnt_o(err_cnt),
      .frame_cnt_o(frame_cnt), .state_o(state)
`ifdef KDCHK_ERR_CAPTURE_EN
      , .cap_valid_o(cap_valid), .cap_rx_o(cap_rx), .cap_exp_o(cap_exp), .cap_idx_o(cap_idx)
`endif
   );

   kd_pattern_checker #(.LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(4), .FRM_W(16)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .k_i(k), .clear_i(clear),
      .locked_o(locked4), .err_pulse_o(err_pulse4), .err_cnt_o(err_cnt4),
      .frame_cnt_o(frame_cnt4), .state_o(state4)
`ifdef KDCHK_ERR_CAPTURE_EN
      , .cap_valid_o(cap_valid4), .cap_rx_o(cap_rx4), .cap_exp_o(cap_exp4), .cap_idx_o(cap_idx4)
`endif
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       kf;
      logic       clr;
      logic [1:0] st;
      logic       lk;
      logic       pl;
      int         err;
      int         frm;
   } vec_t;

   vec_t tbl [20];

   function automatic logic [8:0] sym(input int i);
      logic [7:0] kb [12];
      kb = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
             8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
      if (i < 12) return {1'b1, kb[i]};
      return {1'b0, 8'(i - 12)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic kf, input logic clr);
      valid = v;
      data  = d;
      k     = kf;
      clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [7:0] mask, input logic clr);
      logic [8:0] s;
      s = sym(tb_idx);
      drive(1'b1, s[7:0] ^ mask, s[8], clr);
      tb_idx = (tb_idx + 1) % 268;
   endtask

   task automatic run_n(input int n, input bit gaps);
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(1, 0) == 1) begin
            drive(1'b0, 8'($urandom), 1'b0, 1'b0);
            saw = saw | err_pulse;
         end
         send_sym(8'h00, 1'b0);
         saw = saw | err_pulse;
      end
      chk("run_no_pulse", 32'(saw), 32'd0);
   endtask

   task automatic chk_all(input string nm, input logic [1:0] st, input logic lk,
                          input logic pl, input int err, input int frm);
      chk({nm, ".state"},  32'(state),     32'(st));
      chk({nm, ".locked"}, 32'(locked),    32'(lk));
      chk({nm, ".pulse"},  32'(err_pulse), 32'(pl));
      chk({nm, ".err"},    32'(err_cnt),   32'(err));
      chk({nm, ".frame"},  32'(frame_cnt), 32'(frm));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] s;

      // Hunt / sync vectors: two non-K28.0 symbols and an idle cycle are ignored,
      // then 16 clean symbols from K28.0 (with one idle gap) reach lock.
      tbl[0] = '{1'b1, 8'h1C, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0};
      tbl[1] = '{1'b1, 8'hBC, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0};
      tbl[2] = '{1'b0, 8'h1C, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         s = sym(i);
         tbl[3 + i] = '{1'b1, s[7:0], s[8], 1'b0, 2'd1, 1'b0, 1'b0, 0, 0};
      end
      s = sym(8);
      tbl[11] = '{1'b0, s[7:0], s[8], 1'b0, 2'd1, 1'b0, 1'b0, 0, 0};
      for (int i = 8; i < 16; i++) begin
         s = sym(i);
         tbl[4 + i] = '{1'b1, s[7:0], s[8], 1'b0, (i == 15) ? 2'd2 : 2'd1,
                        (i == 15), 1'b0, 0, 0};
      end

      rst_n = 1'b0;
      valid = 1'b0; data = 8'h00; k = 1'b0; clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 2'd0, 1'b0, 1'b0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].kf, tbl[i].clr);
         chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lk, tbl[i].pl, tbl[i].err, tbl[i].frm);
      end
      tb_idx = 16;

      // First frame: counted on idx 267, not before.
      run_n(251, 1'b0);
      chk("frame_before_267", 32'(frame_cnt), 32'd0);
      send_sym(8'h00, 1'b0);
      chk_all("frame1", 2'd2, 1'b1, 1'b0, 0, 1);

      // A full frame with random idle gaps counts exactly like a gapless one.
      run_n(268, 1'b1);
      chk_all("frame2_gaps", 2'd2, 1'b1, 1'b0, 0, 2);

      // Single corrupted byte 0x37 -> 0x38.
      run_n(67, 1'b0);
      send_sym(8'h0F, 1'b0);
      chk_all("err_0x37", 2'd2, 1'b1, 1'b1, 1, 2);
      send_sym(8'h00, 1'b0);
      chk("err_pulse_one_cycle", 32'(err_pulse), 32'd0);
      run_n(199, 1'b0);
      chk("errored_frame_not_counted", 32'(frame_cnt), 32'd2);
      run_n(268, 1'b0);
      chk("next_frame_counted", 32'(frame_cnt), 32'd3);

      // Clear, then 20 isolated errors: 4-bit counter saturates at 15.
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk_all("clear", 2'd2, 1'b1, 1'b0, 0, 0);
      chk("clear_err4", 32'(err_cnt4), 32'd0);
      run_n(20, 1'b0);
      for (int i = 0; i < 20; i++) begin
         send_sym(8'h01, 1'b0);
         send_sym(8'h00, 1'b0);
      end
      chk("isolated_err16", 32'(err_cnt), 32'd20);
      chk("isolated_err4_sat", 32'(err_cnt4), 32'd15);
      chk("isolated_lock4", 32'(locked4), 32'd1);
      send_sym(8'h01, 1'b1);
      chk_all("clear_with_err", 2'd2, 1'b1, 1'b1, 0, 0);
      chk("clear_with_err4", 32'(err_cnt4), 32'd0);
      run_n(207, 1'b0);
      chk("frame_after_clear_err", 32'(frame_cnt), 32'd0);

      // Four consecutive bad symbols drop lock on the fourth.
      run_n(10, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         send_sym(8'h01, 1'b0);
         chk_all($sformatf("miss%0d", i), 2'd2, 1'b1, 1'b1, i, 0);
      end
      send_sym(8'h01, 1'b0);
      chk_all("miss4_loss", 2'd0, 1'b0, 1'b1, 4, 0);
      run_n(254, 1'b0);
      chk("hunt_until_k28_0", 32'(state), 32'd0);

      // Mismatch during SYNC returns to HUNT without counting.
      run_n(5, 1'b0);
      chk("sync_entered", 32'(state), 32'd1);
      send_sym(8'h01, 1'b0);
      chk_all("sync_mismatch", 2'd0, 1'b0, 1'b1, 4, 0);
      run_n(262, 1'b0);
      run_n(15, 1'b0);
      chk_all("relock_15", 2'd1, 1'b0, 1'b0, 4, 0);
      run_n(1, 1'b0);
      chk_all("relock_16", 2'd2, 1'b1, 1'b0, 4, 0);

      // Asynchronous reset at idx 100 clears outputs without a clock edge.
      run_n(84, 1'b0);
      s = sym(tb_idx);
      valid = 1'b1; data = s[7:0]; k = s[8]; clear = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 2'd0, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_n(168, 1'b0);
      chk("post_reset_hunt", 32'(state), 32'd0);
      run_n(16, 1'b0);
      chk_all("post_reset_lock", 2'd2, 1'b1, 1'b0, 0, 0);
`ifdef KDCHK_ERR_CAPTURE_EN
      chk("cap_valid_idle", 32'(cap_valid), 32'd0);
`endif
      run_n(252, 1'b0);
      chk("post_reset_frame", 32'(frame_cnt), 32'd1);

      // K28.3 received as K28.4, followed by a later error that must not recapture.
      run_n(3, 1'b0);
      send_sym(8'hE0, 1'b0);
      chk_all("k28_3_err", 2'd2, 1'b1, 1'b1, 1, 1);
`ifdef KDCHK_ERR_CAPTURE_EN
      chk("cap_valid", 32'(cap_valid), 32'd1);
      chk("cap_rx",    32'(cap_rx),    32'h19C);
      chk("cap_exp",   32'(cap_exp),   32'h17C);
      chk("cap_idx",   32'(cap_idx),   32'd3);
`endif
      send_sym(8'h00, 1'b0);
      send_sym(8'h01, 1'b0);
      chk("second_err", 32'(err_cnt), 32'd2);
`ifdef KDCHK_ERR_CAPTURE_EN
      chk("cap_hold_idx", 32'(cap_idx), 32'd3);
      chk("cap_hold_rx",  32'(cap_rx),  32'h19C);
`endif
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk_all("final_clear", 2'd2, 1'b1, 1'b0, 0, 0);
`ifdef KDCHK_ERR_CAPTURE_EN
      chk("cap_cleared", 32'(cap_valid), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
